// File: rtl/vend_pkg.sv
// Shared vending-machine types: transaction states, coin codes and coin values.
// Imported by the transaction engine and the HDMI text overlay.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_COLLECTING = 2'b01,
        ST_CHANGE     = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        COIN_5   = 2'b00,
        COIN_10  = 2'b01,
        COIN_25  = 2'b10,
        COIN_100 = 2'b11
    } coin_t;

    function automatic logic [7:0] coin_value(input coin_t code);
        case (code)
            COIN_5:   return 8'd5;
            COIN_10:  return 8'd10;
            COIN_25:  return 8'd25;
            default:  return 8'd100;
        endcase
    endfunction

endpackage

// File: rtl/vend_hold_timer.sv
// Down-counter that times the CHANGE display; done is high during the last
// held cycle so the FSM leaves CHANGE on the same edge the count reaches 0.
module vend_hold_timer #(
    parameter int HOLD_CYCLES = 75_000_000,
    localparam int W = $clog2(HOLD_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam logic [W-1:0] LOAD_VAL = W'(HOLD_CYCLES);

    logic [W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= LOAD_VAL;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign done = (count_q == W'(1));

endmodule

// File: rtl/vend_controller.sv
// Vending transaction engine: credits coins, arbitrates cancel > select > coin,
// and drives the registered status bus for the overlay plus one-cycle strobes.
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE_0     = 75,
    parameter int PRICE_1     = 50,
    parameter int PRICE_2     = 100,
    parameter int PRICE_3     = 125,
    parameter int MAX_TOTAL   = 200,
    parameter int HOLD_CYCLES = 75_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_code,
    input  logic       sel_valid,
    input  logic [1:0] sel_item,
    input  logic       cancel,
    output logic [1:0] state,
    output logic [7:0] total,
    output logic [7:0] change,
    output logic [1:0] selected_item,
    output logic       show_text,
    output logic       dispense,
    output logic       coin_reject,
    output logic       sel_denied
);

    function automatic logic [7:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'(PRICE_0);
            2'd1:    return 8'(PRICE_1);
            2'd2:    return 8'(PRICE_2);
            default: return 8'(PRICE_3);
        endcase
    endfunction

    state_t     state_q, state_n;
    logic [7:0] total_n, change_n;
    logic [1:0] item_n;
    logic       dispense_n, reject_n, denied_n;
    logic       hold_load, hold_done;
    logic [8:0] coin_sum;
    logic       coin_fits;
    logic [7:0] price;

    vend_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
        .clk  (clk),
        .rst  (rst),
        .load (hold_load),
        .done (hold_done)
    );

    // Nine-bit sum so an over-limit coin is refused rather than wrapping.
    assign coin_sum  = {1'b0, total} + {1'b0, coin_value(coin_t'(coin_code))};
    assign coin_fits = (coin_sum <= 9'(MAX_TOTAL));
    assign price     = price_of(sel_item);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_n    = state_q;
        total_n    = total;
        change_n   = change;
        item_n     = selected_item;
        dispense_n = 1'b0;
        reject_n   = 1'b0;
        denied_n   = 1'b0;
        hold_load  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cancel) begin
                    reject_n = coin_valid;
                end else if (sel_valid) begin
                    denied_n = 1'b1;
                    reject_n = coin_valid;
                end else if (coin_valid) begin
                    if (coin_fits) begin
                        total_n = coin_sum[7:0];
                        state_n = ST_COLLECTING;
                    end else begin
                        reject_n = 1'b1;
                    end
                end
            end

            ST_COLLECTING: begin
                if (cancel) begin
                    change_n  = total;
                    total_n   = 8'd0;
                    state_n   = ST_CHANGE;
                    hold_load = 1'b1;
                    reject_n  = coin_valid;
                end else if (sel_valid) begin
                    reject_n = coin_valid;
                    if (total >= price) begin
                        change_n   = total - price;
                        item_n     = sel_item;
                        dispense_n = 1'b1;
                        total_n    = 8'd0;
                        state_n    = ST_CHANGE;
                        hold_load  = 1'b1;
                    end else begin
                        denied_n = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_fits) begin
                        total_n = coin_sum[7:0];
                    end else begin
                        reject_n = 1'b1;
                    end
                end
            end

            ST_CHANGE: begin
                reject_n = coin_valid;
                denied_n = sel_valid;
                if (hold_done) begin
                    change_n = 8'd0;
                    state_n  = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            total         <= 8'd0;
            change        <= 8'd0;
            selected_item <= 2'd0;
            show_text     <= 1'b1;
            dispense      <= 1'b0;
            coin_reject   <= 1'b0;
            sel_denied    <= 1'b0;
        end else begin
            state_q       <= state_n;
            total         <= total_n;
            change        <= change_n;
            selected_item <= item_n;
            dispense      <= dispense_n;
            coin_reject   <= reject_n;
            sel_denied    <= denied_n;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_vend_controller.sv
// Scenario bench for vend_controller: each step pushes its expected output
// bus to a queue, which is popped and compared one cycle later.
module tb_vend_controller;
    import vend_pkg::*;

    localparam int HOLD = 8;

    localparam logic [1:0] C5   = 2'b00;
    localparam logic [1:0] C10  = 2'b01;
    localparam logic [1:0] C25  = 2'b10;
    localparam logic [1:0] C100 = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_code = 2'b00;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_item = 2'b00;
    logic       cancel = 1'b0;
    logic [1:0] state;
    logic [7:0] total;
    logic [7:0] change;
    logic [1:0] selected_item;
    logic       show_text;
    logic       dispense;
    logic       coin_reject;
    logic       sel_denied;

    vend_controller #(.HOLD_CYCLES(HOLD)) dut (
        .clk           (clk),
        .rst           (rst),
        .coin_valid    (coin_valid),
        .coin_code     (coin_code),
        .sel_valid     (sel_valid),
        .sel_item      (sel_item),
        .cancel        (cancel),
        .state         (state),
        .total         (total),
        .change        (change),
        .selected_item (selected_item),
        .show_text     (show_text),
        .dispense      (dispense),
        .coin_reject   (coin_reject),
        .sel_denied    (sel_denied)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic [7:0] tot;
        logic [7:0] chg;
        logic [1:0] item;
        logic       disp;
        logic       rej;
        logic       den;
    } obs_t;

    typedef struct {
        logic       cv;
        logic [1:0] cc;
        logic       sv;
        logic [1:0] si;
        logic       cn;
        obs_t       want;
        string      name;
    } step_t;

    int   errors = 0;
    int   checks = 0;
    obs_t exp_q[$];

    function automatic obs_t o(input logic [1:0] st, input int tot, input int chg,
                               input logic [1:0] item, input logic d, input logic r,
                               input logic s);
        obs_t v;
        v.st = st; v.tot = 8'(tot); v.chg = 8'(chg); v.item = item;
        v.disp = d; v.rej = r; v.den = s;
        return v;
    endfunction

    function automatic obs_t sample();
        obs_t v;
        v.st = state; v.tot = total; v.chg = change; v.item = selected_item;
        v.disp = dispense; v.rej = coin_reject; v.den = sel_denied;
        return v;
    endfunction

    function automatic string fmt(input obs_t v);
        return $sformatf("st=%0d tot=%0d chg=%0d item=%0d disp=%0b rej=%0b den=%0b",
                         v.st, v.tot, v.chg, v.item, v.disp, v.rej, v.den);
    endfunction

    function automatic step_t mk(input logic cv, input logic [1:0] cc, input logic sv,
                                 input logic [1:0] si, input logic cn, input obs_t e,
                                 input string n);
        step_t s;
        s.cv = cv; s.cc = cc; s.sv = sv; s.si = si; s.cn = cn; s.want = e; s.name = n;
        return s;
    endfunction

    function automatic step_t coin_s(input logic [1:0] cc, input obs_t e, input string n);
        return mk(1'b1, cc, 1'b0, 2'd0, 1'b0, e, n);
    endfunction

    function automatic step_t sel_s(input logic [1:0] si, input obs_t e, input string n);
        return mk(1'b0, 2'd0, 1'b1, si, 1'b0, e, n);
    endfunction

    function automatic step_t idle_s(input obs_t e, input string n);
        return mk(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, e, n);
    endfunction

    // Drive one cycle of stimulus; outputs are valid #1 after the capturing edge.
    task automatic apply(input step_t s);
        @(negedge clk);
        coin_valid = s.cv; coin_code = s.cc;
        sel_valid  = s.sv; sel_item  = s.si;
        cancel     = s.cn;
        exp_q.push_back(s.want);
        @(posedge clk);
        #1;
        coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got, want;
        exp_q.push_back(o(ST_IDLE, 0, 0, 2'd0, 0, 0, 0));
        do_reset();
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            errors++; $display("FAIL reset_state: got %s, expected %s", fmt(got), fmt(want));
        end
        checks++;
        if (show_text !== 1'b1) begin
            errors++; $display("FAIL reset_show_text: got %b, expected 1", show_text);
        end
    endtask

    task automatic test_coins();
        step_t s[$];
        obs_t  got, want;
        do_reset();
        s.push_back(coin_s(C25, o(ST_COLLECTING, 25, 0, 2'd0, 0, 0, 0), "coin_q1"));
        s.push_back(coin_s(C25, o(ST_COLLECTING, 50, 0, 2'd0, 0, 0, 0), "coin_q2"));
        s.push_back(coin_s(C10, o(ST_COLLECTING, 60, 0, 2'd0, 0, 0, 0), "coin_dime"));
        foreach (s[i]) begin
            apply(s[i]);
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL %s: got %s, expected %s", s[i].name, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_dispense_hold();
        step_t s[$];
        obs_t  got, want;
        do_reset();
        s.push_back(coin_s(C25, o(ST_COLLECTING, 25, 0, 2'd0, 0, 0, 0), "d_q1"));
        s.push_back(coin_s(C25, o(ST_COLLECTING, 50, 0, 2'd0, 0, 0, 0), "d_q2"));
        s.push_back(coin_s(C25, o(ST_COLLECTING, 75, 0, 2'd0, 0, 0, 0), "d_q3"));
        s.push_back(sel_s(2'd0, o(ST_CHANGE, 0, 0, 2'd0, 1, 0, 0), "d_sel0"));
        // Seven more CHANGE cycles, poking coin/select/cancel while holding.
        s.push_back(idle_s(o(ST_CHANGE, 0, 0, 2'd0, 0, 0, 0), "hold_1"));
        s.push_back(coin_s(C25, o(ST_CHANGE, 0, 0, 2'd0, 0, 1, 0), "hold_2_coin"));
        s.push_back(idle_s(o(ST_CHANGE, 0, 0, 2'd0, 0, 0, 0), "hold_3"));
        s.push_back(sel_s(2'd3, o(ST_CHANGE, 0, 0, 2'd0, 0, 0, 1), "hold_4_sel"));
        s.push_back(idle_s(o(ST_CHANGE, 0, 0, 2'd0, 0, 0, 0), "hold_5"));
        s.push_back(mk(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, o(ST_CHANGE, 0, 0, 2'd0, 0, 0, 0), "hold_6_cancel"));
        s.push_back(idle_s(o(ST_CHANGE, 0, 0, 2'd0, 0, 0, 0), "hold_7"));
        s.push_back(idle_s(o(ST_IDLE, 0, 0, 2'd0, 0, 0, 0), "hold_expire"));
        s.push_back(sel_s(2'd1, o(ST_IDLE, 0, 0, 2'd0, 0, 0, 1), "idle_sel"));
        s.push_back(mk(1'b1, C100, 1'b0, 2'd0, 1'b1, o(ST_IDLE, 0, 0, 2'd0, 0, 1, 0), "idle_cancel_coin"));
        foreach (s[i]) begin
            apply(s[i]);
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL %s: got %s, expected %s", s[i].name, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_change();
        step_t s[$];
        obs_t  got, want;
        do_reset();
        s.push_back(coin_s(C100, o(ST_COLLECTING, 100, 0, 2'd0, 0, 0, 0), "c_dollar"));
        s.push_back(coin_s(C10, o(ST_COLLECTING, 110, 0, 2'd0, 0, 0, 0), "c_dime"));
        s.push_back(mk(1'b1, C5, 1'b1, 2'd2, 1'b0, o(ST_CHANGE, 0, 10, 2'd2, 1, 1, 0), "c_sel2_coin"));
        s.push_back(idle_s(o(ST_CHANGE, 0, 10, 2'd2, 0, 0, 0), "c_pulse_drop"));
        foreach (s[i]) begin
            apply(s[i]);
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL %s: got %s, expected %s", s[i].name, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_denied();
        step_t s[$];
        obs_t  got, want;
        do_reset();
        s.push_back(coin_s(C25, o(ST_COLLECTING, 25, 0, 2'd0, 0, 0, 0), "n_q"));
        s.push_back(coin_s(C10, o(ST_COLLECTING, 35, 0, 2'd0, 0, 0, 0), "n_dime"));
        s.push_back(coin_s(C5, o(ST_COLLECTING, 40, 0, 2'd0, 0, 0, 0), "n_nickel"));
        s.push_back(sel_s(2'd1, o(ST_COLLECTING, 40, 0, 2'd0, 0, 0, 1), "n_sel1_short"));
        s.push_back(idle_s(o(ST_COLLECTING, 40, 0, 2'd0, 0, 0, 0), "n_denied_drop"));
        s.push_back(coin_s(C10, o(ST_COLLECTING, 50, 0, 2'd0, 0, 0, 0), "n_dime2"));
        s.push_back(sel_s(2'd1, o(ST_CHANGE, 0, 0, 2'd1, 1, 0, 0), "n_sel1_exact"));
        foreach (s[i]) begin
            apply(s[i]);
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL %s: got %s, expected %s", s[i].name, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_cancel_coin();
        step_t s[$];
        obs_t  got, want;
        do_reset();
        s.push_back(coin_s(C100, o(ST_COLLECTING, 100, 0, 2'd0, 0, 0, 0), "x_dollar"));
        s.push_back(coin_s(C25, o(ST_COLLECTING, 125, 0, 2'd0, 0, 0, 0), "x_q"));
        s.push_back(mk(1'b1, C10, 1'b0, 2'd0, 1'b1, o(ST_CHANGE, 0, 125, 2'd0, 0, 1, 0), "x_cancel_coin"));
        foreach (s[i]) begin
            apply(s[i]);
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL %s: got %s, expected %s", s[i].name, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_max_total();
        step_t s[$];
        obs_t  got, want;
        do_reset();
        s.push_back(coin_s(C100, o(ST_COLLECTING, 100, 0, 2'd0, 0, 0, 0), "m_dollar"));
        s.push_back(coin_s(C25, o(ST_COLLECTING, 125, 0, 2'd0, 0, 0, 0), "m_q1"));
        s.push_back(coin_s(C25, o(ST_COLLECTING, 150, 0, 2'd0, 0, 0, 0), "m_q2"));
        s.push_back(coin_s(C25, o(ST_COLLECTING, 175, 0, 2'd0, 0, 0, 0), "m_q3"));
        s.push_back(coin_s(C5, o(ST_COLLECTING, 180, 0, 2'd0, 0, 0, 0), "m_nickel"));
        s.push_back(coin_s(C100, o(ST_COLLECTING, 180, 0, 2'd0, 0, 1, 0), "m_dollar_over"));
        s.push_back(coin_s(C10, o(ST_COLLECTING, 190, 0, 2'd0, 0, 0, 0), "m_dime1"));
        s.push_back(coin_s(C10, o(ST_COLLECTING, 200, 0, 2'd0, 0, 0, 0), "m_dime_at_max"));
        s.push_back(coin_s(C5, o(ST_COLLECTING, 200, 0, 2'd0, 0, 1, 0), "m_nickel_over"));
        foreach (s[i]) begin
            apply(s[i]);
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL %s: got %s, expected %s", s[i].name, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_reset_in_change();
        step_t s[$];
        obs_t  got, want;
        do_reset();
        s.push_back(coin_s(C100, o(ST_COLLECTING, 100, 0, 2'd0, 0, 0, 0), "r_dollar"));
        s.push_back(mk(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, o(ST_CHANGE, 0, 100, 2'd0, 0, 0, 0), "r_cancel"));
        foreach (s[i]) begin
            apply(s[i]);
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL %s: got %s, expected %s", s[i].name, fmt(got), fmt(want));
            end
        end
        exp_q.push_back(o(ST_IDLE, 0, 0, 2'd0, 0, 0, 0));
        do_reset();
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            errors++; $display("FAIL r_reset_bus: got %s, expected %s", fmt(got), fmt(want));
        end
        checks++;
        if (dut.u_hold_timer.count_q !== '0) begin
            errors++; $display("FAIL r_hold_cleared: got %0d, expected 0", dut.u_hold_timer.count_q);
        end
        s.delete();
        s.push_back(coin_s(C25, o(ST_COLLECTING, 25, 0, 2'd0, 0, 0, 0), "r_after_q"));
        s.push_back(idle_s(o(ST_COLLECTING, 25, 0, 2'd0, 0, 0, 0), "r_after_idle"));
        foreach (s[i]) begin
            apply(s[i]);
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL %s: got %s, expected %s", s[i].name, fmt(got), fmt(want));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_coins();
        test_dispense_hold();
        test_change();
        test_denied();
        test_cancel_coin();
        test_max_total();
        test_reset_in_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
